dual_issue_hazard_ctrl: RTL



---
 rtl/dual_issue_hazard_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dual_issue_hazard_ctrl.sv
// Stall/flush controller for the dual-issue pipeline: load-use, data-memory wait FSM with timeout, branch flush.
// Stall/flush outputs are combinational from state and inputs; FSM, error flag and stall counter update on clk.
module dual_issue_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsd,
  input  logic [4:0]       rtd,
  input  logic [4:0]       rsd2,
  input  logic [4:0]       rtd2,
  input  logic [4:0]       writerege,
  input  logic [4:0]       writerege2,
  input  logic             memtorege,
  input  logic             memtorege2,
  input  logic             memreqm,
  input  logic             dmem_ready,
  input  logic             branchtakend,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             stallw,
  output logic             stallw2,
  output logic             flushd,
  output logic             flushe,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, ERR} state_t;

  localparam int WC = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [WC-1:0] wait_cnt;
  logic          lu;
  logic          ms;

  // r0 is hardwired zero, so it can never carry a load-use dependency
  function automatic logic src_hit(input logic [4:0] r);
    return (r != 5'd0) &&
           ((memtorege  && (r == writerege)) ||
            (memtorege2 && (r == writerege2)));
  endfunction

  always_comb begin
    lu = src_hit(rsd) | src_hit(rtd) | src_hit(rsd2) | src_hit(rtd2);
    ms = ((state == IDLE) && memreqm && !dmem_ready) ||
         ((state == MEM_WAIT) && !dmem_ready) ||
         (state == ERR);
  end

  always_comb begin
    stallf  = 1'b0;
    stalld  = 1'b0;
    stalle  = 1'b0;
    stallm  = 1'b0;
    stallw  = 1'b0;
    stallw2 = 1'b0;
    flushd  = 1'b0;
    flushe  = 1'b0;
    // Reset gating keeps outputs quiet even while inputs still request a wait
    if (!rst) begin
      if (ms) begin
        stallf  = 1'b1;
        stalld  = 1'b1;
        stalle  = 1'b1;
        stallm  = 1'b1;
        stallw  = 1'b1;
        stallw2 = 1'b1;
      end else if (lu) begin
        stallf = 1'b1;
        stalld = 1'b1;
        flushe = 1'b1;
      end else if (branchtakend) begin
        flushd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memreqm && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == WC'(TIMEOUT - 1)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stallf && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
